// File: rtl/processor.sv
// 8-bit accumulator processor running a built-in GCD program from a 32x8 unified memory.
// Define DEBUG_PORTS_EN to drive the debug display outputs; otherwise they are tied to 0.
module processor (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       enter,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       halt,
  output logic [4:0] IR40,
  output logic [4:0] MeminstOut,
  output logic [7:0] regAOut,
  output logic [7:0] RAMout,
  output logic [3:0] DisplayState,
  output logic [2:0] IR75
);

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoad   = 4'd8,
    StStore  = 4'd9,
    StAdd    = 4'd10,
    StSub    = 4'd11,
    StInput  = 4'd12,
    StJz     = 4'd13,
    StJpos   = 4'd14,
    StHalt   = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] mem_q [32];
  logic [7:0] mem_d [32];
  logic [4:0] addr;
  logic [7:0] mem_rdata;

  // GCD program image; everything past address 15 is zero.
  function automatic logic [7:0] boot_image(input logic [4:0] idx);
    case (idx)
      5'd0:    boot_image = 8'h80;
      5'd1:    boot_image = 8'h3E;
      5'd2:    boot_image = 8'h80;
      5'd3:    boot_image = 8'h3F;
      5'd4:    boot_image = 8'h1E;
      5'd5:    boot_image = 8'h7F;
      5'd6:    boot_image = 8'hAE;
      5'd7:    boot_image = 8'hCC;
      5'd8:    boot_image = 8'h1F;
      5'd9:    boot_image = 8'h7E;
      5'd10:   boot_image = 8'h3F;
      5'd11:   boot_image = 8'hC4;
      5'd12:   boot_image = 8'h3E;
      5'd13:   boot_image = 8'hC4;
      5'd14:   boot_image = 8'h1E;
      5'd15:   boot_image = 8'hE0;
      default: boot_image = 8'h00;
    endcase
  endfunction

  assign addr      = (state_q == StFetch) ? pc_q : ir_q[4:0];
  assign mem_rdata = mem_q[addr];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    mem_d   = mem_q;
    if (init) begin
      // Soft restart: accumulator and memory survive.
      pc_d    = 5'd0;
      state_d = StStart;
    end else begin
      case (state_q)
        StStart: state_d = StFetch;
        StFetch: begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 5'd1;
          state_d = StDecode;
        end
        StDecode: begin
          case (ir_q[7:5])
            3'b000: state_d = StLoad;
            3'b001: state_d = StStore;
            3'b010: state_d = StAdd;
            3'b011: state_d = StSub;
            3'b100: state_d = StInput;
            3'b101: state_d = StJz;
            3'b110: state_d = StJpos;
            3'b111: state_d = StHalt;
          endcase
        end
        StLoad: begin
          a_d     = mem_rdata;
          state_d = StFetch;
        end
        StStore: begin
          mem_d[addr] = a_q;
          state_d     = StFetch;
        end
        StAdd: begin
          a_d     = a_q + mem_rdata;
          state_d = StFetch;
        end
        StSub: begin
          a_d     = a_q - mem_rdata;
          state_d = StFetch;
        end
        StInput: begin
          if (enter) begin
            a_d     = in;
            state_d = StFetch;
          end
        end
        StJz: begin
          if (a_q == 8'd0) pc_d = ir_q[4:0];
          state_d = StFetch;
        end
        StJpos: begin
          if (!a_q[7] && (a_q != 8'd0)) pc_d = ir_q[4:0];
          state_d = StFetch;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StStart;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStart;
      pc_q    <= 5'd0;
      ir_q    <= 8'd0;
      a_q     <= 8'd0;
      for (int i = 0; i < 32; i++) mem_q[i] <= boot_image(5'(i));
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      mem_q   <= mem_d;
    end
  end

  assign out  = a_q;
  assign halt = (state_q == StHalt);

`ifdef DEBUG_PORTS_EN
  assign IR40         = ir_q[4:0];
  assign MeminstOut   = addr;
  assign regAOut      = a_q;
  assign RAMout       = mem_rdata;
  assign DisplayState = state_q;
  assign IR75         = ir_q[7:5];
`else
  assign IR40         = 5'd0;
  assign MeminstOut   = 5'd0;
  assign regAOut      = 8'd0;
  assign RAMout       = 8'd0;
  assign DisplayState = 4'd0;
  assign IR75         = 3'd0;
`endif

endmodule

// File: tb/tb_processor.sv
// Directed bench for the GCD accumulator processor; debug-port expectations follow DEBUG_PORTS_EN.
module tb_processor;

  logic       clk = 1'b0;
  logic       reset, init, enter;
  logic [7:0] in;
  logic [7:0] out;
  logic       halt;
  logic [4:0] IR40, MeminstOut;
  logic [7:0] regAOut, RAMout;
  logic [3:0] DisplayState;
  logic [2:0] IR75;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DEBUG_PORTS_EN
  localparam bit Dbg = 1'b1;
`else
  localparam bit Dbg = 1'b0;
`endif

  processor dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .enter        (enter),
    .in           (in),
    .out          (out),
    .halt         (halt),
    .IR40         (IR40),
    .MeminstOut   (MeminstOut),
    .regAOut      (regAOut),
    .RAMout       (RAMout),
    .DisplayState (DisplayState),
    .IR75         (IR75)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dbg(input logic [31:0] v);
    return Dbg ? v : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enter_val(input logic [7:0] v);
    in    = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  // Starts from START with init held; INPUT is reached 3 edges after init falls,
  // the second IN is reached 5 edges after the first operand is taken.
  task automatic run(input logic [7:0] x, input logic [7:0] y);
    init = 1'b0;
    tick(3);
    check("run_in1_state", DisplayState, dbg(12));
    enter_val(x);
    check("run_x_taken", out, x);
    tick(5);
    check("run_in2_state", DisplayState, dbg(12));
    enter_val(y);
    check("run_y_taken", out, y);
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halt && k < 500) begin
      tick();
      k++;
    end
    check(tag, halt, 1);
  endtask

  initial begin
    reset = 1'b1;
    init  = 1'b1;
    enter = 1'b0;
    in    = 8'd0;
    tick(2);
    check("rst_out", out, 0);
    check("rst_halt", halt, 0);
    check("rst_state", DisplayState, 0);
    check("rst_ram0", RAMout, dbg(8'h80));
    check("rst_ir40", IR40, 0);
    check("rst_addr", MeminstOut, 0);
    reset = 1'b0;
    tick(4);
    check("init_state", DisplayState, 0);
    check("init_out", out, 0);
    check("init_halt", halt, 0);

    // Idle in INPUT with enter low.
    init = 1'b0;
    tick(3);
    check("idle_state_a", DisplayState, dbg(12));
    check("idle_ir75", IR75, dbg(4));
    tick(5);
    check("idle_state_b", DisplayState, dbg(12));
    check("idle_out", out, 0);
    check("idle_halt", halt, 0);
    enter_val(8'd8);
    check("x8_taken", out, 8);
    tick(5);
    check("in2_state", DisplayState, dbg(12));
    enter_val(8'd4);
    check("y4_taken", out, 4);
    wait_halt("halt_8_4");
    check("gcd_8_4", out, 4);
    check("halt_state", DisplayState, dbg(15));
    check("halt_ir75", IR75, dbg(7));
    tick(3);
    check("halt_absorb", halt, 1);

    // init from HALT keeps A.
    init = 1'b1;
    tick(2);
    check("init_halt_state", DisplayState, dbg(0));
    check("init_halt_halt", halt, 0);
    check("init_halt_out", out, 4);

    // Reset in the middle of the 12/18 loop.
    run(8'd12, 8'd18);
    tick(10);
    check("mid_no_halt", halt, 0);
    reset = 1'b1;
    init  = 1'b1;
    tick();
    check("mid_rst_out", out, 0);
    check("mid_rst_halt", halt, 0);
    check("mid_rst_state", DisplayState, 0);
    check("mid_rst_ram0", RAMout, dbg(8'h80));
    reset = 1'b0;
    tick();

    run(8'd12, 8'd18);
    wait_halt("halt_12_18");
    check("gcd_12_18", out, 6);

    init = 1'b1;
    tick();
    run(8'd7, 8'd7);
    wait_halt("halt_7_7");
    check("gcd_7_7", out, 7);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run(8'd8, 8'd4);
    wait_halt("halt_8_4_rerun");
    check("gcd_8_4_rerun", out, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
